// File: rtl/sat_pkg.sv
// Shared types and sizing for the BCP implication queue and its FIFO.
package sat_pkg;

  localparam int NUM_VARIABLE = 128;
  localparam int VAR_W        = 7;
  localparam int CLAUSE_W     = 10;
  localparam int DEPTH        = 16;
  localparam int PTR_W        = $clog2(DEPTH);
  localparam int CNT_W        = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [VAR_W-1:0]    var_idx;
    logic                val;
    logic [CLAUSE_W-1:0] clause;
  } implication_t;

  // Advance a FIFO pointer; wraps naturally because DEPTH is a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + {{(PTR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/implication_fifo.sv
// Synchronous FIFO of implications with exact occupancy count and synchronous clear.
// Storage is cleared too so the head fields read as zero after a clear.
module implication_fifo
  import sat_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  implication_t      din,
  output implication_t      dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  implication_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == {CNT_W{1'b0}});
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[head];

  // Storage write, pointer advance and occupancy tracking.
  always_ff @(posedge clock) begin
    if (clear) begin
      head  <= {PTR_W{1'b0}};
      tail  <= {PTR_W{1'b0}};
      count <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {$bits(implication_t){1'b0}};
      end
    end else begin
      if (do_push) begin
        mem[tail] <= din;
        tail      <= ptr_inc(tail);
      end
      if (do_pop) begin
        head <= ptr_inc(head);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bcp_implication_queue.sv
// Buffers clause-evaluator implications for the assignment stage, collapses
// duplicates of a pending variable and latches the first conflict seen.
module bcp_implication_queue
  import sat_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_unit,
  input  logic                in_falsified,
  input  logic [VAR_W-1:0]    in_var,
  input  logic                in_val,
  input  logic [CLAUSE_W-1:0] in_clause,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [VAR_W-1:0]    out_var,
  output logic                out_val,
  output logic [CLAUSE_W-1:0] out_clause,
  output logic                conflict,
  output logic [VAR_W-1:0]    conflict_var,
  output logic [CLAUSE_W-1:0] conflict_clause,
  output logic [CNT_W-1:0]    count
);

  logic [NUM_VARIABLE-1:0] pending;
  logic [NUM_VARIABLE-1:0] pend_val;
  implication_t            head_entry;
  implication_t            new_entry;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    clear;
  logic                    accept;
  logic                    pop;
  logic                    pop_same;
  logic                    push_en;
  logic                    raise;

  assign clear     = reset | flush;
  assign in_ready  = ~fifo_full | conflict;
  assign out_valid = ~fifo_empty & ~conflict;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign pop_same  = pop & (head_entry.var_idx == in_var);
  assign new_entry = '{var_idx: in_var, val: in_val, clause: in_clause};

  assign out_var    = head_entry.var_idx;
  assign out_val    = head_entry.val;
  assign out_clause = head_entry.clause;

  // Classify an accepted evaluator result against the registered pending map.
  // A same-value hit on the variable leaving the head this cycle re-enqueues.
  always_comb begin
    push_en = 1'b0;
    raise   = 1'b0;
    if (accept && !conflict) begin
      if (in_falsified) begin
        raise = 1'b1;
      end else if (in_unit) begin
        if (!pending[in_var]) begin
          push_en = 1'b1;
        end else if (pend_val[in_var] != in_val) begin
          raise = 1'b1;
        end else if (pop_same) begin
          push_en = 1'b1;
        end else begin
          push_en = 1'b0;
        end
      end else begin
        push_en = 1'b0;
      end
    end else begin
      push_en = 1'b0;
    end
  end

  implication_fifo u_fifo (
    .clock (clock),
    .clear (clear),
    .push  (push_en),
    .pop   (pop),
    .din   (new_entry),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // Pending bitmap: pop clears the head variable, a push in the same cycle wins.
  always_ff @(posedge clock) begin
    if (clear) begin
      pending  <= {NUM_VARIABLE{1'b0}};
      pend_val <= {NUM_VARIABLE{1'b0}};
    end else begin
      if (pop) begin
        pending[head_entry.var_idx] <= 1'b0;
      end
      if (push_en) begin
        pending[in_var]  <= 1'b1;
        pend_val[in_var] <= in_val;
      end
    end
  end

  // Sticky conflict capture; only the first conflict's details are kept.
  always_ff @(posedge clock) begin
    if (clear) begin
      conflict        <= 1'b0;
      conflict_var    <= {VAR_W{1'b0}};
      conflict_clause <= {CLAUSE_W{1'b0}};
    end else if (raise) begin
      conflict        <= 1'b1;
      conflict_var    <= in_falsified ? {VAR_W{1'b0}} : in_var;
      conflict_clause <= in_clause;
    end else begin
      conflict        <= conflict;
      conflict_var    <= conflict_var;
      conflict_clause <= conflict_clause;
    end
  end

endmodule

// File: tb/tb_bcp_implication_queue.sv
// Directed bench for bcp_implication_queue with a scoreboard queue and a
// separate monitor comparing every popped head entry.
module tb_bcp_implication_queue;
  import sat_pkg::*;

  logic                clock;
  logic                reset;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic                in_unit;
  logic                in_falsified;
  logic [VAR_W-1:0]    in_var;
  logic                in_val;
  logic [CLAUSE_W-1:0] in_clause;
  logic                out_valid;
  logic                out_ready;
  logic [VAR_W-1:0]    out_var;
  logic                out_val;
  logic [CLAUSE_W-1:0] out_clause;
  logic                conflict;
  logic [VAR_W-1:0]    conflict_var;
  logic [CLAUSE_W-1:0] conflict_clause;
  logic [CNT_W-1:0]    count;

  int checks = 0;
  int errors = 0;
  implication_t exp_q[$];

  bcp_implication_queue dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_unit         (in_unit),
    .in_falsified    (in_falsified),
    .in_var          (in_var),
    .in_val          (in_val),
    .in_clause       (in_clause),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_var         (out_var),
    .out_val         (out_val),
    .out_clause      (out_clause),
    .conflict        (conflict),
    .conflict_var    (conflict_var),
    .conflict_clause (conflict_clause),
    .count           (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one transfer pattern for n cycles starting just after a rising edge.
  task automatic drive(input bit rdy, input bit v, input bit unit, input bit fals,
                       input int vr, input bit vl, input int cl, input int n);
    @(posedge clock); #1;
    out_ready    = rdy;
    in_valid     = v;
    in_unit      = unit;
    in_falsified = fals;
    in_var       = VAR_W'(vr);
    in_val       = vl;
    in_clause    = CLAUSE_W'(cl);
    repeat (n) begin
      @(posedge clock); #1;
    end
    out_ready    = 1'b0;
    in_valid     = 1'b0;
    in_unit      = 1'b0;
    in_falsified = 1'b0;
  endtask

  task automatic push_unit(input int vr, input bit vl, input int cl, input bit expect_enq);
    implication_t e;
    if (expect_enq) begin
      e.var_idx = VAR_W'(vr);
      e.val     = vl;
      e.clause  = CLAUSE_W'(cl);
      exp_q.push_back(e);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, vr, vl, cl, 1);
  endtask

  task automatic do_flush();
    @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_idle(input string tag);
    @(negedge clock);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_var"}, 32'(out_var), 32'd0);
    chk({tag, "_out_val"}, 32'(out_val), 32'd0);
    chk({tag, "_out_clause"}, 32'(out_clause), 32'd0);
    chk({tag, "_conflict"}, 32'(conflict), 32'd0);
    chk({tag, "_conflict_var"}, 32'(conflict_var), 32'd0);
    chk({tag, "_conflict_clause"}, 32'(conflict_clause), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
  endtask

  // Monitor: every head handed over must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got var %0d with no entry expected", out_var);
      end else begin
        implication_t e;
        e = exp_q.pop_front();
        chk("pop_var", 32'(out_var), 32'(e.var_idx));
        chk("pop_val", 32'(out_val), 32'(e.val));
        chk("pop_clause", 32'(out_clause), 32'(e.clause));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_unit = 1'b0; in_falsified = 1'b0;
    in_var = '0; in_val = 1'b0; in_clause = '0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check_idle("reset");

    // Single push, 1-cycle latency, then pop clears pending for var 5.
    push_unit(5, 1'b1, 12, 1'b1);
    @(negedge clock);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_var", 32'(out_var), 32'd5);
    chk("t1_out_val", 32'(out_val), 32'd1);
    chk("t1_out_clause", 32'(out_clause), 32'd12);
    chk("t1_count", 32'(count), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1);
    @(negedge clock);
    chk("t1_count_after_pop", 32'(count), 32'd0);
    chk("t1_valid_after_pop", 32'(out_valid), 32'd0);
    push_unit(5, 1'b0, 13, 1'b1);
    @(negedge clock);
    chk("t1_repush_count", 32'(count), 32'd1);
    chk("t1_repush_no_conflict", 32'(conflict), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1);

    // Duplicate same-value implication collapses.
    push_unit(9, 1'b0, 20, 1'b1);
    push_unit(9, 1'b0, 21, 1'b0);
    @(negedge clock);
    chk("t2_count", 32'(count), 32'd1);
    chk("t2_conflict", 32'(conflict), 32'd0);

    // Opposite-value implication raises conflict.
    push_unit(9, 1'b1, 40, 1'b0);
    @(negedge clock);
    chk("t3_conflict", 32'(conflict), 32'd1);
    chk("t3_conflict_var", 32'(conflict_var), 32'd9);
    chk("t3_conflict_clause", 32'(conflict_clause), 32'd40);
    chk("t3_out_valid", 32'(out_valid), 32'd0);
    chk("t3_in_ready", 32'(in_ready), 32'd1);
    do_flush();
    check_idle("t3_flush");

    // Falsified clause conflict is sticky and keeps the first details.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 77, 1'b0, 300, 1);
    @(negedge clock);
    chk("t4_conflict", 32'(conflict), 32'd1);
    chk("t4_conflict_var", 32'(conflict_var), 32'd0);
    chk("t4_conflict_clause", 32'(conflict_clause), 32'd300);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 301, 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 50, 1'b1, 302, 1);
    @(negedge clock);
    chk("t4_keep_clause", 32'(conflict_clause), 32'd300);
    chk("t4_keep_var", 32'(conflict_var), 32'd0);
    chk("t4_discard_count", 32'(count), 32'd0);
    chk("t4_in_ready", 32'(in_ready), 32'd1);
    do_flush();
    check_idle("t4_flush");

    // Offset pointers, fill to full, refused push during pop, drain across wrap.
    for (int i = 0; i < 3; i++) push_unit(60 + i, 1'b1, 500 + i, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 3);
    @(negedge clock);
    chk("t5_offset_count", 32'(count), 32'd0);
    for (int i = 0; i < 16; i++) push_unit(i * 7 + 1, i[0], 100 + i, 1'b1);
    @(negedge clock);
    chk("t5_full_count", 32'(count), 32'd16);
    chk("t5_full_in_ready", 32'(in_ready), 32'd0);
    chk("t5_full_out_valid", 32'(out_valid), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 120, 1'b1, 400, 1);
    @(negedge clock);
    chk("t5_refused_count", 32'(count), 32'd15);
    chk("t5_in_ready_after", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 15);
    @(negedge clock);
    chk("t5_drained_count", 32'(count), 32'd0);
    chk("t5_drained_valid", 32'(out_valid), 32'd0);
    chk("t5_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Same-cycle pop and same-value push of var 3 re-enqueues it.
    push_unit(3, 1'b1, 200, 1'b1);
    push_unit(4, 1'b0, 201, 1'b1);
    begin
      implication_t e;
      e.var_idx = VAR_W'(3); e.val = 1'b1; e.clause = CLAUSE_W'(202);
      exp_q.push_back(e);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b1, 202, 1);
    @(negedge clock);
    chk("t6_count_unchanged", 32'(count), 32'd2);
    push_unit(3, 1'b1, 204, 1'b0);
    @(negedge clock);
    chk("t6_pending_kept", 32'(count), 32'd2);
    chk("t6_no_conflict", 32'(conflict), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 2);
    @(negedge clock);
    chk("t6_drained", 32'(count), 32'd0);

    // Same-cycle pop and opposite-value push still conflicts.
    push_unit(8, 1'b0, 210, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8, 1'b1, 211, 1);
    @(negedge clock);
    chk("t7_conflict", 32'(conflict), 32'd1);
    chk("t7_conflict_var", 32'(conflict_var), 32'd8);
    chk("t7_conflict_clause", 32'(conflict_clause), 32'd211);
    chk("t7_count", 32'(count), 32'd0);
    do_flush();
    check_idle("t7_flush");

    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
